// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Purpose  : Sequential instruction fetch with an in-order prefetch queue,
//            stale-response dropping on redirect, valid/ready drain to decode.
// Revision : 1.0
// ============================================================================
module instr_fetch_queue #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 DEPTH     = 4,
    parameter int                 PC_STEP   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_next,
    input  logic               id_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    // Stale responses can outnumber DEPTH after back-to-back redirects.
    localparam int DW = PW + 4;

    localparam logic [PW-1:0]     PTR_ONE  = 1;
    localparam logic [CW-1:0]     CNT_ONE  = 1;
    localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);
    localparam logic [DW-1:0]     DROP_ONE = 1;
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [PW-1:0]      head, tail, fill_ptr;
    logic [CW-1:0]      alloc_cnt, unfilled_cnt;
    logic [DW-1:0]      drop_cnt;
    logic [ADDR_W-1:0]  pc_q    [DEPTH];
    logic [INSTR_W-1:0] instr_q [DEPTH];

    logic               grant, pop, fill, discard, head_ready;
    logic [DW-1:0]      drop_sum, drop_redir;

    assign imem_req   = rst_n && !redirect && (alloc_cnt < CNT_FULL);
    assign imem_addr  = fetch_pc;
    assign grant      = imem_req && imem_gnt;

    // Filled entries are always contiguous from the head.
    assign head_ready = (alloc_cnt != unfilled_cnt);
    assign if_valid   = !redirect && head_ready;
    assign pop        = if_valid && id_ready;

    assign fill       = imem_rvalid && !redirect && (drop_cnt == '0) && (unfilled_cnt != '0);
    assign discard    = imem_rvalid && !redirect && (drop_cnt != '0);

    assign drop_sum   = DW'(unfilled_cnt) + drop_cnt;
    assign drop_redir = (imem_rvalid && (drop_sum != '0)) ? (drop_sum - DROP_ONE) : drop_sum;

    assign if_instr   = if_valid ? instr_q[head] : NOP_INSTR;
    assign if_pc      = if_valid ? pc_q[head] : '0;
    assign if_pc_next = if_pc + STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            fill_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            drop_cnt     <= '0;
        end else if (redirect) begin
            fetch_pc     <= redirect_pc;
            head         <= '0;
            tail         <= '0;
            fill_ptr     <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            drop_cnt     <= drop_redir;
        end else begin
            if (grant) begin
                tail     <= tail + PTR_ONE;
                fetch_pc <= fetch_pc + STEP;
            end
            if (fill)
                fill_ptr <= fill_ptr + PTR_ONE;
            if (pop)
                head <= head + PTR_ONE;
            if (discard)
                drop_cnt <= drop_cnt - DROP_ONE;

            if (grant && !pop)
                alloc_cnt <= alloc_cnt + CNT_ONE;
            else if (!grant && pop)
                alloc_cnt <= alloc_cnt - CNT_ONE;

            if (grant && !fill)
                unfilled_cnt <= unfilled_cnt + CNT_ONE;
            else if (!grant && fill)
                unfilled_cnt <= unfilled_cnt - CNT_ONE;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (grant)
            pc_q[tail] <= fetch_pc;
        if (fill)
            instr_q[fill_ptr] <= imem_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Purpose  : Self-checking bench for instr_fetch_queue (vector table, directed
//            corner sequences, randomized traffic against a queue model).
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid, redirect, id_ready, if_valid;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, if_instr, if_pc, if_pc_next;

    logic        w_req, w_valid;
    logic [7:0]  w_addr, w_pc, w_pc_next;
    logic [31:0] w_instr;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .PC_STEP(4),
        .RESET_PC(32'h0), .NOP_INSTR(32'h0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_next(if_pc_next), .id_ready(id_ready)
    );

    instr_fetch_queue #(
        .ADDR_W(8), .INSTR_W(32), .DEPTH(4), .PC_STEP(4),
        .RESET_PC(8'hF8), .NOP_INSTR(32'h0)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(1'b0), .imem_rdata(32'h0),
        .redirect(1'b0), .redirect_pc(8'h0),
        .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc),
        .if_pc_next(w_pc_next), .id_ready(1'b0)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    string seg     = "init";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got 0x%08h expected 0x%08h at t=%0t", seg, name, act, exp, $time);
        end
    endtask

    // Reference model: live entries of the current fetch epoch, plus the
    // memory's outstanding responses tagged as live or stale.
    typedef struct { logic [31:0] pc; logic [31:0] data; bit filled; } live_t;
    typedef struct { logic [31:0] data; bit live; int due; }             mem_t;

    live_t       live_q[$];
    mem_t        mem_q[$];
    logic [31:0] m_pc;
    logic [15:0] tag;
    int          cyc, last_due;

    logic        obs_req, obs_valid, obs_grant;
    logic [31:0] obs_addr, obs_pc, obs_instr;

    task automatic run_cycle(input bit g, input bit r, input bit rd,
                             input logic [31:0] rpc, input int lat);
        bit          rv, e_req, e_valid, done;
        logic [31:0] e_pc, e_instr, d;
        live_t       h;
        mem_t        m;
        int          due;

        rv          = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_q[0].data : $urandom;
        id_ready    = r;
        redirect    = rd;
        redirect_pc = rpc;

        e_req   = !rd && (live_q.size() < DEPTH);
        e_valid = 1'b0;
        e_pc    = 32'h0;
        e_instr = 32'h0;
        if (!rd && live_q.size() > 0 && live_q[0].filled) begin
            e_valid = 1'b1;
            e_pc    = live_q[0].pc;
            e_instr = live_q[0].data;
        end

        @(negedge clk);
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = if_valid;
        obs_pc    = if_pc;
        obs_instr = if_instr;
        obs_grant = imem_req && imem_gnt;
        chk("imem_req",   32'(imem_req), 32'(e_req));
        chk("imem_addr",  imem_addr,     m_pc);
        chk("if_valid",   32'(if_valid), 32'(e_valid));
        chk("if_instr",   if_instr,      e_instr);
        chk("if_pc",      if_pc,         e_pc);
        chk("if_pc_next", if_pc_next,    e_pc + 32'd4);

        @(posedge clk);
        if (rv) begin
            m = mem_q.pop_front();
            if (m.live && !rd) begin
                done = 1'b0;
                for (int i = 0; i < live_q.size(); i++) begin
                    if (!done && !live_q[i].filled) begin
                        h = live_q[i];
                        h.filled = 1'b1;
                        live_q[i] = h;
                        done = 1'b1;
                    end
                end
            end
        end
        if (rd) begin
            for (int i = 0; i < mem_q.size(); i++) begin
                m = mem_q[i];
                m.live = 1'b0;
                mem_q[i] = m;
            end
            live_q.delete();
            m_pc = rpc;
        end else begin
            if (e_valid && r)
                void'(live_q.pop_front());
            if (e_req && g) begin
                d        = {tag, m_pc[15:0]};
                h.pc     = m_pc;
                h.data   = d;
                h.filled = 1'b0;
                live_q.push_back(h);
                due = cyc + lat;
                if (due <= last_due)
                    due = last_due + 1;
                last_due = due;
                m.data = d;
                m.live = 1'b1;
                m.due  = due;
                mem_q.push_back(m);
                m_pc = m_pc + 32'd4;
                tag  = tag + 16'd1;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        live_q.delete();
        mem_q.delete();
        m_pc     = 32'h0;
        cyc      = 0;
        last_due = -1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        bit g, r, rd; logic [31:0] rpc;
        bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc;
    } vec_t;

    vec_t vt[14];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit          seen;
        int          gcount;
        logic [31:0] got[$];
        logic [7:0]  w_exp[5];

        tag = 16'h1;
        rst_n = 1'b0;
        idle_inputs();
        #3;
        seg = "reset";
        chk("imem_req",   32'(imem_req), 32'h0);
        chk("imem_addr",  imem_addr,     32'h0);
        chk("if_valid",   32'(if_valid), 32'h0);
        chk("if_instr",   if_instr,      32'h0);
        chk("if_pc",      if_pc,         32'h0);
        chk("if_pc_next", if_pc_next,    32'h4);

        // Startup latency, stall/hold, full queue, redirect with no stale traffic.
        vt[0]  = '{1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0};
        vt[1]  = '{1, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0};
        vt[2]  = '{1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0};
        vt[3]  = '{1, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4};
        vt[4]  = '{0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h8};
        vt[5]  = '{1, 0, 0, 32'h0,   1, 32'h10,  1, 32'h8};
        vt[6]  = '{1, 0, 0, 32'h0,   1, 32'h14,  1, 32'h8};
        vt[7]  = '{1, 0, 0, 32'h0,   0, 32'h18,  1, 32'h8};
        vt[8]  = '{0, 1, 1, 32'h100, 0, 32'h18,  0, 32'h0};
        vt[9]  = '{1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
        vt[10] = '{1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0};
        vt[11] = '{0, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100};
        vt[12] = '{0, 1, 0, 32'h0,   1, 32'h108, 1, 32'h104};
        vt[13] = '{0, 1, 0, 32'h0,   1, 32'h108, 0, 32'h0};

        do_reset();
        seg = "table";
        for (int i = 0; i < 14; i++) begin
            run_cycle(vt[i].g, vt[i].r, vt[i].rd, vt[i].rpc, 1);
            chk("vec_req",   32'(obs_req),   32'(vt[i].e_req));
            chk("vec_addr",  obs_addr,       vt[i].e_addr);
            chk("vec_valid", 32'(obs_valid), 32'(vt[i].e_valid));
            chk("vec_pc",    obs_pc,         vt[i].e_pc);
        end

        do_reset();
        seg = "stall";
        gcount = 0;
        repeat (10) begin
            run_cycle(1, 0, 0, 32'h0, 1);
            if (obs_grant) gcount++;
        end
        chk("grants", 32'(gcount), 32'd4);
        chk("req_low", 32'(obs_req), 32'h0);
        got.delete();
        repeat (8) begin
            run_cycle(0, 1, 0, 32'h0, 1);
            if (obs_valid) got.push_back(obs_pc);
        end
        chk("delivered", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) chk("order", got[i], 32'(i * 4));

        do_reset();
        seg = "stale_drop";
        run_cycle(1, 0, 0, 32'h0, 3);
        run_cycle(1, 0, 0, 32'h0, 3);
        run_cycle(0, 0, 1, 32'h100, 1);
        seen = 1'b0;
        repeat (10) begin
            run_cycle(1, 1, 0, 32'h0, 1);
            if (obs_valid && !seen) begin
                seen = 1'b1;
                chk("first_pc", obs_pc, 32'h100);
                chk("first_data", {16'h0, obs_instr[15:0]}, 32'h100);
            end
        end
        chk("seen_valid", 32'(seen), 32'h1);

        do_reset();
        seg = "redir_rvalid_pop";
        repeat (5) run_cycle(1, 1, 0, 32'h0, 1);
        run_cycle(1, 1, 1, 32'h200, 1);
        chk("no_xfer", 32'(obs_valid), 32'h0);
        run_cycle(1, 1, 0, 32'h0, 1);
        chk("restart_req", 32'(obs_req), 32'h1);
        chk("restart_addr", obs_addr, 32'h200);
        repeat (4) run_cycle(1, 1, 0, 32'h0, 1);
        chk("resume_pc", obs_pc, 32'h208);

        do_reset();
        seg = "wrap";
        w_exp = '{8'hF8, 8'hFC, 8'h00, 8'h04, 8'h08};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("w_req",  32'(w_req),  (i < 4) ? 32'h1 : 32'h0);
            chk("w_addr", 32'(w_addr), 32'(w_exp[i]));
            @(posedge clk);
            #1;
        end
        chk("w_valid", 32'(w_valid), 32'h0);
        chk("w_instr", w_instr, 32'h0);
        chk("w_pc_next", 32'(w_pc_next), 32'h4);

        do_reset();
        seg = "async_reset";
        repeat (6) run_cycle(1, 0, 0, 32'h0, 1);
        chk("full_req_low", 32'(obs_req), 32'h0);
        chk("full_valid", 32'(obs_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("imem_req",   32'(imem_req), 32'h0);
        chk("imem_addr",  imem_addr,     32'h0);
        chk("if_valid",   32'(if_valid), 32'h0);
        chk("if_instr",   if_instr,      32'h0);
        chk("if_pc",      if_pc,         32'h0);
        chk("if_pc_next", if_pc_next,    32'h4);
        do_reset();
        run_cycle(1, 1, 0, 32'h0, 1);
        chk("restart_addr", obs_addr, 32'h0);
        repeat (4) run_cycle(1, 1, 0, 32'h0, 1);

        do_reset();
        seg = "random";
        for (int i = 0; i < 600; i++) begin
            run_cycle($urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) != 0,
                      $urandom_range(0, 15) == 0,
                      $urandom & 32'hFFFF_FFFC,
                      int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
